// File: rtl/move_parser_if.sv
// Byte-in / move-out handshake bundle for move_parser.
// master = parser side (byte consumer, move initiator); slave = environment side.
interface move_parser_if #(
  parameter int DIST_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_direction;
  logic [DIST_W-1:0] out_distance;
  logic              out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_direction, out_distance
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_direction, out_distance
  );
endinterface

// File: rtl/move_parser.sv
// Parses ASCII rotation records ("L68\n", "R1204\r\n") into (direction, distance) moves.
// Optional MOVE_PARSER_ERR_CNT_EN adds a saturating err_count output.
module move_parser #(
  parameter int DIST_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  move_parser_if.master    bus,
  output logic [CNT_W-1:0] move_count,
`ifdef MOVE_PARSER_ERR_CNT_EN
  output logic [CNT_W-1:0] err_count,
`endif
  output logic             err
);

  localparam int WIDE = DIST_W + 4;

  typedef enum logic [1:0] {IDLE, DIGITS, SKIP, HOLD} state_t;

  state_t            state;
  logic              dir;
  logic              have_digit;
  logic              sat;
  logic [DIST_W-1:0] acc;

  logic              byte_fire;
  logic              is_digit;
  logic [WIDE-1:0]   acc_x10;
  logic              acc_ovf;
  logic [DIST_W-1:0] acc_next;

  // acc*10 + digit at DIST_W+4 bits; anything above DIST_W bits is overflow.
  always_comb begin
    byte_fire = bus.in_valid && bus.in_ready;
    is_digit  = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    acc_x10   = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + WIDE'(bus.in_data[3:0]);
    acc_ovf   = |acc_x10[WIDE-1:DIST_W];
    acc_next  = acc_ovf ? {DIST_W{1'b1}} : acc_x10[DIST_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.out_direction <= 1'b0;
      bus.out_distance  <= '0;
      move_count        <= '0;
      err               <= 1'b0;
      dir               <= 1'b0;
      have_digit        <= 1'b0;
      sat               <= 1'b0;
      acc               <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (byte_fire) begin
          case (bus.in_data)
            8'h4C, 8'h52: begin
              dir        <= (bus.in_data == 8'h52);
              acc        <= '0;
              have_digit <= 1'b0;
              sat        <= 1'b0;
              state      <= DIGITS;
            end
            8'h0A, 8'h0D, 8'h20: ;
            default: begin
              err   <= 1'b1;
              state <= SKIP;
            end
          endcase
        end
        DIGITS: if (byte_fire) begin
          if (is_digit) begin
            acc        <= acc_next;
            have_digit <= 1'b1;
            // Saturation is reported once per record, not once per extra digit.
            if (acc_ovf && !sat) begin
              sat <= 1'b1;
              err <= 1'b1;
            end
          end else if (bus.in_data == 8'h0D) begin
            // carriage return before the newline is tolerated
          end else if (bus.in_data == 8'h0A) begin
            if (have_digit) begin
              bus.out_valid     <= 1'b1;
              bus.out_direction <= dir;
              bus.out_distance  <= acc;
              bus.in_ready      <= 1'b0;
              state             <= HOLD;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            err   <= 1'b1;
            state <= SKIP;
          end
        end
        SKIP: if (byte_fire && bus.in_data == 8'h0A) state <= IDLE;
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          move_count    <= move_count + 1'b1;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MOVE_PARSER_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err_count <= '0;
    else if (err && !(&err_count)) err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_move_parser.sv
// Directed self-checking bench for move_parser: drives byte strings, checks moves and err pulses.
module tb_move_parser;
  localparam int DIST_W = 16;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] move_count;
  logic             err;
`ifdef MOVE_PARSER_ERR_CNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  int errors = 0;
  int checks = 0;

  move_parser_if #(.DIST_W(DIST_W)) mif ();

  move_parser #(.DIST_W(DIST_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (mif.master),
    .move_count (move_count),
`ifdef MOVE_PARSER_ERR_CNT_EN
    .err_count  (err_count),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  // Move/err observer: everything sampled on the edge where it takes effect.
  int          mv_n = 0;
  int          err_seen = 0;
  logic        mv_dir  [64];
  logic [31:0] mv_dist [64];
  always @(posedge clk) begin
    if (mif.out_valid && mif.out_ready && mv_n < 64) begin
      mv_dir[mv_n]  <= mif.out_direction;
      mv_dist[mv_n] <= 32'(mif.out_distance);
      mv_n          <= mv_n + 1;
    end
    if (err) err_seen <= err_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    mif.in_valid = 1'b1;
    mif.in_data  = b;
    while (!mif.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    mif.in_valid = 1'b0;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(1);
  endtask

  int m0, e0;

  initial begin
    rst           = 1'b1;
    mif.in_valid  = 1'b0;
    mif.in_data   = 8'h00;
    mif.out_ready = 1'b0;
    cycles(2);
    chk("rst_in_ready",  32'(mif.in_ready),      32'd1);
    chk("rst_out_valid", 32'(mif.out_valid),     32'd0);
    chk("rst_out_dir",   32'(mif.out_direction), 32'd0);
    chk("rst_out_dist",  32'(mif.out_distance),  32'd0);
    chk("rst_move_cnt",  32'(move_count),        32'd0);
    chk("rst_err",       32'(err),               32'd0);
    rst = 1'b0;
    cycles(1);

    // "L68\nR48\n" with consumer always ready; out_valid one cycle after each newline
    mif.out_ready = 1'b1;
    m0 = mv_n; e0 = err_seen;
    send_str("L68");
    send(8'h0A);
    chk("t1_lat1_valid", 32'(mif.out_valid),    32'd1);
    chk("t1_lat1_inrdy", 32'(mif.in_ready),     32'd0);
    chk("t1_lat1_dist",  32'(mif.out_distance), 32'd68);
    send_str("R48");
    send(8'h0A);
    chk("t1_lat2_valid", 32'(mif.out_valid),    32'd1);
    cycles(2);
    chk("t1_moves",      32'(mv_n - m0),        32'd2);
    chk("t1_m0_dir",     32'(mv_dir[m0]),       32'd0);
    chk("t1_m0_dist",    mv_dist[m0],           32'd68);
    chk("t1_m1_dir",     32'(mv_dir[m0+1]),     32'd1);
    chk("t1_m1_dist",    mv_dist[m0+1],         32'd48);
    chk("t1_move_count", 32'(move_count),       32'd2);
    chk("t1_err",        32'(err_seen - e0),    32'd0);

    // "R1000\r\n" with back-pressure for 5 cycles
    do_reset();
    mif.out_ready = 1'b0;
    m0 = mv_n;
    send_str("R1000\r\n");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(mif.out_valid),     32'd1);
      chk("t2_hold_dist",  32'(mif.out_distance),  32'd1000);
      chk("t2_hold_dir",   32'(mif.out_direction), 32'd1);
      chk("t2_hold_inrdy", 32'(mif.in_ready),      32'd0);
      cycles(1);
    end
    chk("t2_no_xfer",    32'(mv_n - m0),       32'd0);
    mif.out_ready = 1'b1;
    cycles(1);
    chk("t2_valid_drop", 32'(mif.out_valid),   32'd0);
    chk("t2_inrdy_back", 32'(mif.in_ready),    32'd1);
    chk("t2_move_count", 32'(move_count),      32'd1);
    cycles(2);
    chk("t2_moves",      32'(mv_n - m0),       32'd1);
    chk("t2_dist",       mv_dist[m0],          32'd1000);

    // malformed records: bad lead byte, and a direction with no digits
    do_reset();
    m0 = mv_n; e0 = err_seen;
    send_str("X12\nL\nL5\n");
    cycles(3);
    chk("t3_err",        32'(err_seen - e0),   32'd2);
    chk("t3_moves",      32'(mv_n - m0),       32'd1);
    chk("t3_dir",        32'(mv_dir[m0]),      32'd0);
    chk("t3_dist",       mv_dist[m0],          32'd5);
    chk("t3_move_count", 32'(move_count),      32'd1);

    // saturation of the distance accumulator
    do_reset();
    m0 = mv_n; e0 = err_seen;
    send_str("R70000\n");
    cycles(3);
    chk("t4_err",        32'(err_seen - e0),   32'd1);
    chk("t4_moves",      32'(mv_n - m0),       32'd1);
    chk("t4_dir",        32'(mv_dir[m0]),      32'd1);
    chk("t4_dist",       mv_dist[m0],          32'd65535);

    // distance zero is legal; whitespace lines in IDLE are ignored
    do_reset();
    m0 = mv_n; e0 = err_seen;
    send_str(" \r\nR0\n");
    cycles(3);
    chk("t5_moves",      32'(mv_n - m0),       32'd1);
    chk("t5_dist",       mv_dist[m0],          32'd0);
    chk("t5_err",        32'(err_seen - e0),   32'd0);

    // reset mid-record drops the partial move
    do_reset();
    m0 = mv_n;
    send_str("L4");
    rst = 1'b1;
    #1;
    chk("t6_rst_inrdy",  32'(mif.in_ready),      32'd1);
    chk("t6_rst_valid",  32'(mif.out_valid),     32'd0);
    chk("t6_rst_dist",   32'(mif.out_distance),  32'd0);
    chk("t6_rst_mcnt",   32'(move_count),        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_str("R7\n");
    cycles(3);
    chk("t6_moves",      32'(mv_n - m0),       32'd1);
    chk("t6_dir",        32'(mv_dir[m0]),      32'd1);
    chk("t6_dist",       mv_dist[m0],          32'd7);
    chk("t6_move_count", 32'(move_count),      32'd1);

`ifdef MOVE_PARSER_ERR_CNT_EN
    do_reset();
    chk("t7_errcnt_rst", 32'(err_count),       32'd0);
    send_str("?\n?\n?\n");
    cycles(3);
    chk("t7_err_count",  32'(err_count),       32'd3);
    chk("t7_move_count", 32'(move_count),      32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
